// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor.
// Operands are consumed DIGIT bits per clock, least-significant digit first,
// with the carry held in a register between digits. A start/busy/done
// handshake frames each operation; results hold until the next done.

module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [DIGIT-1:0] aDig, bDig, digSum;
   logic             digCout;
   logic             msbCarryIn;
   logic [WIDTH-1:0] aShift, bShift, resNext;

   // One DIGIT-bit ripple slice; the carry into its top bit is recovered from a^b^s
   always_comb begin
      aDig       = opA_q[DIGIT-1:0];
      bDig       = opB_q[DIGIT-1:0];
      {digCout, digSum} = {1'b0, aDig} + {1'b0, bDig} + (DIGIT+1)'(c_q);
      msbCarryIn = aDig[DIGIT-1] ^ bDig[DIGIT-1] ^ digSum[DIGIT-1];
   end

   // Operand and result shifting; a single-digit build has nothing left to shift
   if (DIGIT == WIDTH) begin : gSingle
      assign aShift  = '0;
      assign bShift  = '0;
      assign resNext = digSum;
   end else begin : gMulti
      assign aShift  = {{DIGIT{1'b0}}, opA_q[WIDTH-1:DIGIT]};
      assign bShift  = {{DIGIT{1'b0}}, opB_q[WIDTH-1:DIGIT]};
      assign resNext = {digSum, res_q[WIDTH-1:DIGIT]};
   end

   // Next-state logic: capture on accepted start, step one digit per cycle in RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      c_d     = c_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               opA_d   = a;
               opB_d   = sub ? ~b : b;
               c_d     = sub ? 1'b1 : cin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            opA_d = aShift;
            opB_d = bShift;
            c_d   = digCout;
            res_d = resNext;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               sum_d   = resNext;
               carry_d = digCout;
               ovf_d   = msbCarryIn ^ digCout;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset that aborts any operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opA_q   <= '0;
         opB_q   <= '0;
         c_q     <= 1'b0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         c_q     <= c_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign sum      = sum_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: ten instances covering WIDTH 4/8/16 with several
// DIGIT sizes. Expected results go into a scoreboard queue when an operation
// is launched and are popped and compared when done pulses.

module tb_serial_addsub;

   localparam int NCFG = 10;

   function automatic int cfgW(input int i);
      case (i)
         0, 1, 2, 3: return 8;
         4, 5, 6:    return 4;
         default:    return 16;
      endcase
   endfunction

   function automatic int cfgD(input int i);
      case (i)
         0: return 1;  1: return 2;  2: return 4;  3: return 8;
         4: return 1;  5: return 2;  6: return 4;
         7: return 1;  8: return 2;  default: return 16;
      endcase
   endfunction

   typedef struct {
      logic [15:0] sum;
      logic        carry;
      logic        ovf;
   } exp_t;

   typedef struct {
      int          cfg;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        c;
      logic        o;
      int          lat;
   } dir_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] aArr [NCFG];
   logic [15:0] bArr [NCFG];
   logic        cinArr [NCFG];
   logic        subArr [NCFG];
   logic        startArr [NCFG];
   logic [NCFG-1:0]    busyV, doneV, carryV, ovfV;
   logic [NCFG*16-1:0] sumV;

   exp_t sbQ [$];
   exp_t lastRes [NCFG];
   int   nCompared = 0;
   int   nMismatched = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : gDut
      localparam int W = cfgW(g);
      localparam int D = cfgD(g);
      logic [W-1:0] sumW;
      logic busyW, doneW, carryW, ovfW;
      serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
         .clk(clk), .rst(rst), .start(startArr[g]),
         .a(aArr[g][W-1:0]), .b(bArr[g][W-1:0]),
         .cin(cinArr[g]), .sub(subArr[g]),
         .busy(busyW), .done(doneW), .sum(sumW),
         .carry(carryW), .overflow(ovfW)
      );
      assign busyV[g]           = busyW;
      assign doneV[g]           = doneW;
      assign carryV[g]          = carryW;
      assign ovfV[g]            = ovfW;
      assign sumV[g*16 +: 16]   = 16'(sumW);
   end

   // Reference: whole-word add, plus a (w-1)-bit add to get the carry into the MSB
   function automatic exp_t refModel(input int w, input logic [15:0] av, input logic [15:0] bv,
                                     input logic ci, input logic sb);
      int unsigned mask, m1, bb, c0, full, low;
      exp_t r;
      mask = (32'h1 << w) - 1;
      m1   = mask >> 1;
      bb   = sb ? (~32'(bv)) & mask : 32'(bv) & mask;
      c0   = sb ? 32'd1 : 32'(ci);
      full = (32'(av) & mask) + bb + c0;
      low  = (32'(av) & m1) + (bb & m1) + c0;
      r.sum   = 16'(full & mask);
      r.carry = full[w];
      r.ovf   = full[w] ^ low[w-1];
      return r;
   endfunction

   task automatic launch(input int cfg, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb);
      aArr[cfg]     = av;
      bArr[cfg]     = bv;
      cinArr[cfg]   = ci;
      subArr[cfg]   = sb;
      startArr[cfg] = 1'b1;
      @(posedge clk); #1;
      startArr[cfg] = 1'b0;
   endtask

   task automatic waitDone(input int cfg, output int lat);
      lat = 0;
      while (doneV[cfg] !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < NCFG; i++) begin
         aArr[i] = '0; bArr[i] = '0; cinArr[i] = 1'b0; subArr[i] = 1'b0; startArr[i] = 1'b0;
         lastRes[i] = '{16'h0, 1'b0, 1'b0};
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nCompared++; if (busyV !== '0) begin nMismatched++; $display("[TB] FAIL reset busy: got %b expected 0", busyV); end
      nCompared++; if (doneV !== '0) begin nMismatched++; $display("[TB] FAIL reset done: got %b expected 0", doneV); end
      nCompared++; if (carryV !== '0) begin nMismatched++; $display("[TB] FAIL reset carry: got %b expected 0", carryV); end
      nCompared++; if (ovfV !== '0) begin nMismatched++; $display("[TB] FAIL reset overflow: got %b expected 0", ovfV); end
      nCompared++; if (sumV !== '0) begin nMismatched++; $display("[TB] FAIL reset sum: got %h expected 0", sumV); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      dir_t tab [8];
      exp_t e;
      int lat;
      tab = '{
         '{0, 16'h5A, 16'h3C, 1'b0, 1'b0, 16'h96, 1'b0, 1'b1, 8},
         '{0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 8},
         '{0, 16'hFF, 16'h01, 1'b1, 1'b0, 16'h01, 1'b1, 1'b0, 8},
         '{0, 16'h10, 16'h20, 1'b0, 1'b1, 16'hF0, 1'b0, 1'b0, 8},
         '{0, 16'h10, 16'h20, 1'b1, 1'b1, 16'hF0, 1'b0, 1'b0, 8},
         '{0, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1, 8},
         '{2, 16'h5A, 16'h3C, 1'b0, 1'b0, 16'h96, 1'b0, 1'b1, 2},
         '{3, 16'h5A, 16'h3C, 1'b0, 1'b0, 16'h96, 1'b0, 1'b1, 1}
      };
      foreach (tab[i]) begin
         launch(tab[i].cfg, tab[i].a, tab[i].b, tab[i].cin, tab[i].sub);
         sbQ.push_back('{tab[i].s, tab[i].c, tab[i].o});
         waitDone(tab[i].cfg, lat);
         nCompared++; if (lat !== tab[i].lat) begin nMismatched++; $display("[TB] FAIL directed%0d latency: got %0d expected %0d", i, lat, tab[i].lat); end
         e = sbQ.pop_front();
         lastRes[tab[i].cfg] = e;
         nCompared++; if (sumV[tab[i].cfg*16 +: 16] !== e.sum) begin nMismatched++; $display("[TB] FAIL directed%0d sum: got %h expected %h", i, sumV[tab[i].cfg*16 +: 16], e.sum); end
         nCompared++; if (carryV[tab[i].cfg] !== e.carry) begin nMismatched++; $display("[TB] FAIL directed%0d carry: got %b expected %b", i, carryV[tab[i].cfg], e.carry); end
         nCompared++; if (ovfV[tab[i].cfg] !== e.ovf) begin nMismatched++; $display("[TB] FAIL directed%0d overflow: got %b expected %b", i, ovfV[tab[i].cfg], e.ovf); end
         @(posedge clk); #1;
         nCompared++; if (doneV[tab[i].cfg] !== 1'b0) begin nMismatched++; $display("[TB] FAIL directed%0d done width: got %b expected 0", i, doneV[tab[i].cfg]); end
         nCompared++; if (sumV[tab[i].cfg*16 +: 16] !== e.sum) begin nMismatched++; $display("[TB] FAIL directed%0d sum hold: got %h expected %h", i, sumV[tab[i].cfg*16 +: 16], e.sum); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic expDone;
      for (int c = 0; c < 27; c++) begin
         aArr[0]     = 16'($urandom_range(0, 255));
         bArr[0]     = 16'($urandom_range(0, 255));
         cinArr[0]   = 1'($urandom_range(0, 1));
         subArr[0]   = 1'($urandom_range(0, 1));
         startArr[0] = 1'b1;
         if (c % 9 == 0) sbQ.push_back(refModel(8, aArr[0], bArr[0], cinArr[0], subArr[0]));
         @(posedge clk); #1;
         expDone = (c % 9 == 8);
         nCompared++; if (doneV[0] !== expDone) begin nMismatched++; $display("[TB] FAIL b2b done c%0d: got %b expected %b", c, doneV[0], expDone); end
         nCompared++; if (busyV[0] !== !expDone) begin nMismatched++; $display("[TB] FAIL b2b busy c%0d: got %b expected %b", c, busyV[0], !expDone); end
         if (expDone) begin
            if (sbQ.size() > 0) e = sbQ.pop_front();
            lastRes[0] = e;
         end
         nCompared++; if (sumV[15:0] !== lastRes[0].sum) begin nMismatched++; $display("[TB] FAIL b2b sum c%0d: got %h expected %h", c, sumV[15:0], lastRes[0].sum); end
         nCompared++; if (carryV[0] !== lastRes[0].carry || ovfV[0] !== lastRes[0].ovf) begin nMismatched++; $display("[TB] FAIL b2b flags c%0d: got %b%b expected %b%b", c, carryV[0], ovfV[0], lastRes[0].carry, lastRes[0].ovf); end
      end
      startArr[0] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      exp_t e;
      int lat;
      logic sawDone;
      launch(0, 16'hFF, 16'h01, 1'b1, 1'b0);
      sbQ.push_back('{16'h01, 1'b1, 1'b0});
      waitDone(0, lat);
      e = sbQ.pop_front();
      nCompared++; if (sumV[15:0] !== e.sum || carryV[0] !== e.carry) begin nMismatched++; $display("[TB] FAIL abort pre-op: got %h/%b expected %h/%b", sumV[15:0], carryV[0], e.sum, e.carry); end
      @(posedge clk); #1;
      launch(0, 16'hC3, 16'h5A, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NCFG; i++) lastRes[i] = '{16'h0, 1'b0, 1'b0};
      nCompared++; if (busyV[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort busy: got %b expected 0", busyV[0]); end
      nCompared++; if (sumV[15:0] !== 16'h0) begin nMismatched++; $display("[TB] FAIL abort sum: got %h expected 0", sumV[15:0]); end
      nCompared++; if (carryV[0] !== 1'b0 || ovfV[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort flags: got %b%b expected 00", carryV[0], ovfV[0]); end
      sawDone = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (doneV[0] === 1'b1) sawDone = 1'b1;
         @(posedge clk); #1;
      end
      nCompared++; if (sawDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort done: got %b expected 0", sawDone); end
      launch(0, 16'h5A, 16'h3C, 1'b0, 1'b0);
      sbQ.push_back(refModel(8, 16'h5A, 16'h3C, 1'b0, 1'b0));
      waitDone(0, lat);
      nCompared++; if (lat !== 8) begin nMismatched++; $display("[TB] FAIL abort recover latency: got %0d expected 8", lat); end
      e = sbQ.pop_front();
      lastRes[0] = e;
      nCompared++; if (sumV[15:0] !== e.sum || carryV[0] !== e.carry || ovfV[0] !== e.ovf) begin nMismatched++; $display("[TB] FAIL abort recover result: got %h/%b/%b expected %h/%b/%b", sumV[15:0], carryV[0], ovfV[0], e.sum, e.carry, e.ovf); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      exp_t e;
      int lat, w, n;
      logic [15:0] mask, av, bv;
      logic ci, sb;
      for (int cfg = 0; cfg < NCFG; cfg++) begin
         w    = cfgW(cfg);
         n    = w / cfgD(cfg);
         mask = 16'((32'h1 << w) - 1);
         for (int k = 0; k < 12; k++) begin
            av = 16'($urandom) & mask;
            bv = 16'($urandom) & mask;
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            launch(cfg, av, bv, ci, sb);
            sbQ.push_back(refModel(w, av, bv, ci, sb));
            waitDone(cfg, lat);
            nCompared++; if (lat !== n) begin nMismatched++; $display("[TB] FAIL rand cfg%0d latency: got %0d expected %0d", cfg, lat, n); end
            e = sbQ.pop_front();
            nCompared++; if (sumV[cfg*16 +: 16] !== e.sum) begin nMismatched++; $display("[TB] FAIL rand cfg%0d sum a=%h b=%h cin=%b sub=%b: got %h expected %h", cfg, av, bv, ci, sb, sumV[cfg*16 +: 16], e.sum); end
            nCompared++; if (carryV[cfg] !== e.carry) begin nMismatched++; $display("[TB] FAIL rand cfg%0d carry a=%h b=%h: got %b expected %b", cfg, av, bv, carryV[cfg], e.carry); end
            nCompared++; if (ovfV[cfg] !== e.ovf) begin nMismatched++; $display("[TB] FAIL rand cfg%0d overflow a=%h b=%h: got %b expected %b", cfg, av, bv, ovfV[cfg], e.ovf); end
            @(posedge clk); #1;
         end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
